// File: rtl/OoO_pkg.sv
// Shared core types: AXI read-channel bundles and the read-arbiter state encoding.
package OoO_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef struct packed {
        logic                  arvalid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic                  arready;
        logic                  rvalid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } axi_r_s2m_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic ARB_IFU = 1'b0;
    localparam logic ARB_LSU = 1'b1;

endpackage

// File: rtl/ooo_rr_pick2.sv
// Two-request selector: round-robin against the last winner, or fixed priority to req[1].
module ooo_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = req[1];
        if (req == 2'b11) begin
            gnt = rr_en ? ~last : 1'b1;
        end
    end

endmodule

// File: rtl/ooo_axi_rd_arb.sv
// Shares the core AXI read port between IFU and LSU, one burst at a time, with a
// beat-count vs rlast consistency check.
module ooo_axi_rd_arb
    import OoO_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter bit RAW_BLOCK = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    output axi_r_m2s_t core_r_m2s,
    input  axi_r_s2m_t core_r_s2m,
    input  logic       lsu_wr_busy_i,
    output logic       len_err_o
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [7:0] beats_q, beats_d;

    logic [1:0] req;
    logic       pick_gnt;
    logic       pick_any;
    logic       beat;
    axi_r_m2s_t sel_m2s;
    axi_r_s2m_t sel_s2m;

    // LSU reads are held off while one of its writes is in flight (read-after-write).
    assign req = {lsu_r_m2s.arvalid & ~(RAW_BLOCK & lsu_wr_busy_i), ifu_r_m2s.arvalid};

    ooo_rr_pick2 u_pick (
        .req   (req),
        .last  (last_q),
        .rr_en (RR_EN),
        .gnt   (pick_gnt),
        .any   (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beats_d    = beats_q;
        core_r_m2s = '0;
        sel_s2m    = '0;
        beat       = 1'b0;
        len_err_o  = 1'b0;
        sel_m2s    = (gnt_q == ARB_LSU) ? lsu_r_m2s : ifu_r_m2s;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                core_r_m2s        = sel_m2s;
                core_r_m2s.rready = 1'b0;
                sel_s2m.arready   = core_r_s2m.arready;
                if (sel_m2s.arvalid && core_r_s2m.arready) begin
                    beats_d = sel_m2s.arlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                core_r_m2s.rready = sel_m2s.rready;
                sel_s2m           = core_r_s2m;
                sel_s2m.arready   = 1'b0;
                beat              = core_r_s2m.rvalid && sel_m2s.rready;
                if (beat) begin
                    // Overrunning beats saturate at zero so every further beat keeps flagging.
                    len_err_o = core_r_s2m.rlast ? (beats_q != 8'd0) : (beats_q == 8'd0);
                    if (beats_q != 8'd0) begin
                        beats_d = beats_q - 8'd1;
                    end
                    if (core_r_s2m.rlast) begin
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ifu_r_s2m = (gnt_q == ARB_IFU) ? sel_s2m : '0;
        lsu_r_s2m = (gnt_q == ARB_LSU) ? sel_s2m : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= ARB_IFU;
            last_q  <= ARB_LSU;
            beats_q <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

endmodule
